rf_port_arbiter: RTL and testbench
==================================

# rf_port_arbiter

Two-client arbiter for the 8x8 register file's single write port and single read port. Two masters, for example an instruction sequencer and a debug/DMA port, each issue write and read requests. Writes and reads are arbitrated independently with round-robin fairness and a request/grant handshake. The block drives the register file's `d`/`en`/`wsel`/`rsel` directly and returns registered read data with a one-cycle valid pulse.

## Interface
- No parameters: widths fixed at 8-bit data, 3-bit address, 2 clients.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high; also tied to the register file's `clr`.
- `wreq0`, `wreq1`  in  1  write request from client 0/1.
- `waddr0`, `waddr1`  in  3  write register index.
- `wdata0`, `wdata1`  in  8  write data.
- `wgnt0`, `wgnt1`  out  1  write grant, combinational; the write commits at the edge ending this cycle.
- `rreq0`, `rreq1`  in  1  read request.
- `raddr0`, `raddr1`  in  3  read register index.
- `rgnt0`, `rgnt1`  out  1  read grant, combinational.
- `rvalid0`, `rvalid1`  out  1  registered; high for exactly one cycle, the cycle after `rgntN`.
- `rdata0`, `rdata1`  out  8  registered read data; valid when `rvalidN` is high and held until the next read for that client.
- `rf_d`  out  8  to register file `d`.
- `rf_en`  out  1  to register file `en`.
- `rf_wsel`  out  3  to register file `wsel`.
- `rf_rsel`  out  3  to register file `rsel`.
- `rf_q`  in  8  from register file `q` (combinational read).

## Operation
- **Handshake:** a client holds `req` high and its addr/data stable until it sees `gnt` high in a cycle. A transfer occurs in any cycle where `req` and `gnt` are both high. The client may drop or retarget `req` the following cycle.
- **Grant rule (per port):**
  - If only one client requests, it is granted.
  - If both request, the grant goes to the client selected by that port's priority pointer (`wptr` or `rptr`, 1 bit each).
  - At most one grant per port per cycle.
- **Pointer update:** on any granted cycle, the port's pointer becomes the other client (`ptr <= ~granted_id`). With no grant, the pointer holds. The write and read pointers are independent.
- **Write path:**
  - Granted write: `rf_en=1`, `rf_wsel=waddrN`, `rf_d=wdataN`.
  - No write grant: `rf_en=0`, `rf_wsel=0`, `rf_d=0`.
- **Read path:**
  - Granted read: `rf_rsel=raddrN`.
  - No read grant: `rf_rsel=0`.
  - At the edge: `rdataN <= rf_q`, and `rvalidN <= 1` for the granted client only. The other client's `rvalid` is 0.
- **Write-read bypass:** if a write and a read are granted in the same cycle with `waddr == raddr`, the captured `rdata` is the write data (`rf_d`), not the stale `rf_q`. Read-after-write is therefore coherent regardless of client.
- **Simultaneous write and read by the same client:** legal; both ports are granted independently.

## Timing
- Grant latency: 0 cycles (combinational from `req` and the pointer).
- Write latency: the register file holds the new value after the edge ending the grant cycle.
- Read latency: `rdata`/`rvalid` appear 1 cycle after the grant.
- Throughput: 1 write plus 1 read per cycle.
- Under continuous contention, each client is granted every other cycle per port.
- Reset: while `clr`=1, all grants are 0, and `rf_en`, `rf_d`, `rf_wsel`, `rf_rsel` are 0.
  - At the edge: `wptr=0`, `rptr=0`, `rvalid0/1=0`, `rdata0/1=0`.
  - After reset, the first contended grant on each port goes to client 0.
- Reset during an in-flight read (the grant cycle or the cycle after) suppresses `rvalid`. No stale valid is emitted after `clr` falls.
- Requests asserted during `clr` are ignored and must be re-presented after `clr` falls. No request is remembered across reset.

## Test plan
- **Reset:** hold `clr` 2 cycles with all reqs high → all grants 0 and `rf_en`=0. The cycle after release, with both `wreq` high, `wgnt0`=1 and `wgnt1`=0.
- **Single write then read:** client 1 writes 0xA5 to r3; next cycle client 1 reads r3 → `rgnt1`=1, and one cycle later `rvalid1`=1, `rdata1`=0xA5, `rvalid0`=0.
- **Contention fairness:** both clients hold `wreq` for 6 cycles to r0/r1 with distinct data → grants alternate 0,1,0,1,0,1, and the final register contents match the last granted data of each client.
- **Bypass:** r5 holds 0x11; in the same cycle, client 0 writes 0x77 to r5 and client 1 reads r5 → `rdata1`=0x77 the next cycle. Without an address match (read r4), `rdata1` returns r4's old value.
- **Independent ports:** client 0 writes r2=0x3C while client 1 reads r7=0x00 in the same cycle → both granted. `rf_en`=1, `rf_wsel`=2, `rf_rsel`=7; next cycle `rdata1`=0x00.
- **Reset mid-read:** grant a read to client 0, then assert `clr` on the next edge → `rvalid0` never goes high, and `rdata0`=0 after reset.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port and one read port
// between two clients, with registered read return and write-read bypass.
module rf_port_arbiter (
    input  logic       clk,
    input  logic       clr,
    input  logic       wreq0,
    input  logic       wreq1,
    input  logic [2:0] waddr0,
    input  logic [2:0] waddr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       wgnt0,
    output logic       wgnt1,
    input  logic       rreq0,
    input  logic       rreq1,
    input  logic [2:0] raddr0,
    input  logic [2:0] raddr1,
    output logic       rgnt0,
    output logic       rgnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [7:0] rf_d,
    output logic       rf_en,
    output logic [2:0] rf_wsel,
    output logic [2:0] rf_rsel,
    input  logic [7:0] rf_q
);

    logic       wptr;
    logic       rptr;
    logic       rv0_q;
    logic       rv1_q;
    logic       byp;
    logic [7:0] rcap;

    always_comb begin
        wgnt0 = 1'b0;
        wgnt1 = 1'b0;
        rgnt0 = 1'b0;
        rgnt1 = 1'b0;
        if (!clr) begin
            wgnt0 = wreq0 && (!wreq1 || !wptr);
            wgnt1 = wreq1 && (!wreq0 || wptr);
            rgnt0 = rreq0 && (!rreq1 || !rptr);
            rgnt1 = rreq1 && (!rreq0 || rptr);
        end
    end

    always_comb begin
        rf_en   = 1'b0;
        rf_wsel = '0;
        rf_d    = '0;
        unique case (1'b1)
            wgnt0: begin
                rf_en   = 1'b1;
                rf_wsel = waddr0;
                rf_d    = wdata0;
            end
            wgnt1: begin
                rf_en   = 1'b1;
                rf_wsel = waddr1;
                rf_d    = wdata1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_rsel = '0;
        unique case (1'b1)
            rgnt0:   rf_rsel = raddr0;
            rgnt1:   rf_rsel = raddr1;
            default: ;
        endcase
    end

    // A same-cycle write to the register being read wins over the stale array value
    assign byp  = rf_en && (rgnt0 || rgnt1) && (rf_wsel == rf_rsel);
    assign rcap = byp ? rf_d : rf_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (wgnt0 || wgnt1) wptr <= wgnt0;
            if (rgnt0 || rgnt1) rptr <= rgnt0;
            rv0_q <= rgnt0;
            rv1_q <= rgnt1;
            if (rgnt0) rdata0 <= rcap;
            if (rgnt1) rdata1 <= rcap;
        end
    end

    // Reset arriving the cycle after a read grant kills the pending valid
    assign rvalid0 = rv0_q && !clr;
    assign rvalid1 = rv1_q && !clr;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed vector table, reset corner cases,
// then random traffic against a behavioural model with its own register file.
module tb_rf_port_arbiter;

    logic       clk;
    logic       clr;
    logic       wreq0, wreq1;
    logic [2:0] waddr0, waddr1;
    logic [7:0] wdata0, wdata1;
    logic       wgnt0, wgnt1;
    logic       rreq0, rreq1;
    logic [2:0] raddr0, raddr1;
    logic       rgnt0, rgnt1;
    logic       rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] rf_d;
    logic       rf_en;
    logic [2:0] rf_wsel;
    logic [2:0] rf_rsel;
    logic [7:0] rf_q;

    logic [7:0] rf_mem [8];

    int checks;
    int passed;

    rf_port_arbiter dut (
        .clk(clk), .clr(clr),
        .wreq0(wreq0), .wreq1(wreq1),
        .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .wgnt0(wgnt0), .wgnt1(wgnt1),
        .rreq0(rreq0), .rreq1(rreq1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rgnt0(rgnt0), .rgnt1(rgnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rf_d(rf_d), .rf_en(rf_en),
        .rf_wsel(rf_wsel), .rf_rsel(rf_rsel),
        .rf_q(rf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x8 register file sharing the arbiter's clear
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
        end else if (rf_en) begin
            rf_mem[rf_wsel] <= rf_d;
        end
    end
    assign rf_q = rf_mem[rf_rsel];

    typedef struct {
        logic       c;
        logic       wr0, wr1;
        logic [2:0] wa0, wa1;
        logic [7:0] wd0, wd1;
        logic       rr0, rr1;
        logic [2:0] ra0, ra1;
        logic [1:0] egw, egr;
        logic       een;
        logic [2:0] ews;
        logic [7:0] ed;
        logic [2:0] ers;
        logic [1:0] erv;
        logic [7:0] erd0, erd1;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        clr    = v.c;
        wreq0  = v.wr0;
        wreq1  = v.wr1;
        waddr0 = v.wa0;
        waddr1 = v.wa1;
        wdata0 = v.wd0;
        wdata1 = v.wd1;
        rreq0  = v.rr0;
        rreq1  = v.rr1;
        raddr0 = v.ra0;
        raddr1 = v.ra1;
    endtask

    task automatic idle();
        wreq0 = 0; wreq1 = 0; rreq0 = 0; rreq1 = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        raddr0 = 0; raddr1 = 0;
    endtask

    // Reference model state
    logic [7:0] m_mem [8];
    logic       m_wturn, m_rturn;
    logic       m_rv0, m_rv1;
    logic [7:0] m_rd0, m_rd1;

    initial begin
        checks = 0;
        passed = 0;
        clr = 1'b1;
        idle();

        vecs[0]  = '{1,1,1,1,2,8'h55,8'h66,1,1,1,2, 2'b00,2'b00,0,0,8'h00,0, 2'b00,8'h00,8'h00};
        vecs[1]  = vecs[0];
        vecs[2]  = '{0,1,1,0,1,8'h10,8'h20,0,0,0,0, 2'b01,2'b00,1,0,8'h10,0, 2'b00,8'h00,8'h00};
        vecs[3]  = '{0,0,1,0,3,8'h00,8'hA5,0,0,0,0, 2'b10,2'b00,1,3,8'hA5,0, 2'b00,8'h00,8'h00};
        vecs[4]  = '{0,0,0,0,0,8'h00,8'h00,0,1,0,3, 2'b00,2'b10,0,0,8'h00,3, 2'b10,8'h00,8'hA5};
        for (int k = 0; k < 6; k++) begin
            logic ev;
            ev = (k % 2 == 0);
            vecs[5+k] = '{0,1,1,0,1,8'(8'h30 + k),8'(8'h40 + k),0,0,0,0,
                          ev ? 2'b01 : 2'b10, 2'b00, 1, ev ? 3'd0 : 3'd1,
                          ev ? 8'(8'h30 + k) : 8'(8'h40 + k), 0,
                          2'b00, 8'h00, 8'hA5};
        end
        vecs[11] = '{0,0,0,0,0,8'h00,8'h00,1,0,0,0, 2'b00,2'b01,0,0,8'h00,0, 2'b01,8'h34,8'hA5};
        vecs[12] = '{0,0,0,0,0,8'h00,8'h00,0,1,0,1, 2'b00,2'b10,0,0,8'h00,1, 2'b10,8'h34,8'h45};
        vecs[13] = '{0,1,0,5,0,8'h11,8'h00,0,0,0,0, 2'b01,2'b00,1,5,8'h11,0, 2'b00,8'h34,8'h45};
        vecs[14] = '{0,0,1,0,4,8'h00,8'h44,0,0,0,0, 2'b10,2'b00,1,4,8'h44,0, 2'b00,8'h34,8'h45};
        vecs[15] = '{0,1,0,5,0,8'h77,8'h00,0,1,0,5, 2'b01,2'b10,1,5,8'h77,5, 2'b10,8'h34,8'h77};
        vecs[16] = '{0,1,0,5,0,8'h99,8'h00,0,1,0,4, 2'b01,2'b10,1,5,8'h99,4, 2'b10,8'h34,8'h44};
        vecs[17] = '{0,1,0,2,0,8'h3C,8'h00,0,1,0,7, 2'b01,2'b10,1,2,8'h3C,7, 2'b10,8'h34,8'h00};
        vecs[18] = '{0,1,0,6,0,8'h5A,8'h00,1,0,6,0, 2'b01,2'b01,1,6,8'h5A,6, 2'b01,8'h5A,8'h00};
        vecs[19] = '{0,0,0,0,0,8'h00,8'h00,1,1,6,2, 2'b00,2'b10,0,0,8'h00,2, 2'b10,8'h5A,8'h3C};
        vecs[20] = '{0,0,0,0,0,8'h00,8'h00,0,0,0,0, 2'b00,2'b00,0,0,8'h00,0, 2'b00,8'h5A,8'h3C};

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d wgnt", i), {wgnt1, wgnt0}, vecs[i].egw);
            chk($sformatf("v%0d rgnt", i), {rgnt1, rgnt0}, vecs[i].egr);
            chk($sformatf("v%0d rf_en", i), rf_en, vecs[i].een);
            chk($sformatf("v%0d rf_wsel", i), rf_wsel, vecs[i].ews);
            chk($sformatf("v%0d rf_d", i), rf_d, vecs[i].ed);
            chk($sformatf("v%0d rf_rsel", i), rf_rsel, vecs[i].ers);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rvalid", i), {rvalid1, rvalid0}, vecs[i].erv);
            chk($sformatf("v%0d rdata0", i), rdata0, vecs[i].erd0);
            chk($sformatf("v%0d rdata1", i), rdata1, vecs[i].erd1);
        end

        // Reset the cycle after a read grant
        @(negedge clk);
        idle();
        clr = 0;
        rreq0 = 1;
        raddr0 = 6;
        #1 chk("midrd gnt", rgnt0, 1'b1);
        @(posedge clk);
        #1;
        clr = 1;
        rreq0 = 0;
        #1 chk("midrd rv_a", rvalid0, 1'b0);
        @(negedge clk);
        chk("midrd rv_b", rvalid0, 1'b0);
        @(posedge clk);
        #1;
        chk("midrd rv_c", rvalid0, 1'b0);
        chk("midrd rd_c", rdata0, 8'h00);
        @(negedge clk);
        clr = 0;
        @(posedge clk);
        #1;
        chk("midrd rv_d", rvalid0, 1'b0);
        chk("midrd rd_d", rdata0, 8'h00);

        // Request during reset is neither granted nor remembered
        @(negedge clk);
        clr = 1;
        rreq0 = 1;
        wreq1 = 1;
        #1;
        chk("clrgnt r", rgnt0, 1'b0);
        chk("clrgnt w", wgnt1, 1'b0);
        @(negedge clk);
        clr = 0;
        rreq0 = 0;
        wreq1 = 0;
        #1 chk("clrgnt en", rf_en, 1'b0);
        @(posedge clk);
        #1 chk("clrgnt rv", rvalid0, 1'b0);

        // Random traffic against the model, starting from a clean reset
        @(negedge clk);
        idle();
        clr = 1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_wturn = 0;
        m_rturn = 0;
        m_rv0 = 0;
        m_rv1 = 0;
        m_rd0 = 0;
        m_rd1 = 0;

        for (int n = 0; n < 400; n++) begin
            logic ew0, ew1, er0, er1, een;
            logic [2:0] ewa, era;
            logic [7:0] ewd, rval;
            @(negedge clk);
            clr    = ($urandom_range(0, 24) == 0);
            wreq0  = 1'($urandom_range(0, 1));
            wreq1  = 1'($urandom_range(0, 1));
            rreq0  = 1'($urandom_range(0, 1));
            rreq1  = 1'($urandom_range(0, 1));
            waddr0 = 3'($urandom_range(0, 7));
            waddr1 = 3'($urandom_range(0, 7));
            raddr0 = 3'($urandom_range(0, 7));
            raddr1 = 3'($urandom_range(0, 7));
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);

            ew0 = 0; ew1 = 0; er0 = 0; er1 = 0;
            if (!clr) begin
                if (wreq0 && wreq1) begin
                    ew0 = (m_wturn == 0);
                    ew1 = !ew0;
                end else begin
                    ew0 = wreq0;
                    ew1 = wreq1;
                end
                if (rreq0 && rreq1) begin
                    er0 = (m_rturn == 0);
                    er1 = !er0;
                end else begin
                    er0 = rreq0;
                    er1 = rreq1;
                end
            end
            een = ew0 || ew1;
            ewa = ew0 ? waddr0 : (ew1 ? waddr1 : 3'd0);
            ewd = ew0 ? wdata0 : (ew1 ? wdata1 : 8'h00);
            era = er0 ? raddr0 : (er1 ? raddr1 : 3'd0);
            rval = (een && (er0 || er1) && ewa == era) ? ewd : m_mem[era];

            #1;
            chk("rnd wgnt", {wgnt1, wgnt0}, {ew1, ew0});
            chk("rnd rgnt", {rgnt1, rgnt0}, {er1, er0});
            chk("rnd rf_en", rf_en, een);
            chk("rnd rf_wsel", rf_wsel, ewa);
            chk("rnd rf_d", rf_d, ewd);
            chk("rnd rf_rsel", rf_rsel, era);

            if (clr) begin
                for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
                m_wturn = 0;
                m_rturn = 0;
                m_rv0 = 0;
                m_rv1 = 0;
                m_rd0 = 0;
                m_rd1 = 0;
            end else begin
                if (een) begin
                    m_mem[ewa] = ewd;
                    m_wturn = ew0;
                end
                if (er0 || er1) m_rturn = er0;
                m_rv0 = er0;
                m_rv1 = er1;
                if (er0) m_rd0 = rval;
                if (er1) m_rd1 = rval;
            end

            @(posedge clk);
            #1;
            chk("rnd rvalid", {rvalid1, rvalid0}, {m_rv1, m_rv0});
            chk("rnd rdata0", rdata0, m_rd0);
            chk("rnd rdata1", rdata1, m_rd1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
